// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the regfile write-port arbiter.
package rf_arb_pkg;
   localparam int RF_AW   = 5;
   localparam int RF_DW   = 32;
   localparam int RF_NREG = 1 << RF_AW;

   typedef struct packed {
      logic             wen;
      logic [RF_AW-1:0] waddr;
      logic [RF_DW-1:0] wdata;
   } rf_wreq_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for long-latency ops: pend bitmap, outstanding
// count, issue gating and decode hazard stall.
module rf_scoreboard
   import rf_arb_pkg::*;
#(
   parameter int MAX_PEND = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             iss_valid_i,
   input  logic [RF_AW-1:0] iss_waddr_i,
   output logic             iss_ready_o,
   input  logic             commit_i,
   input  logic [RF_AW-1:0] commit_waddr_i,
   input  logic [RF_AW-1:0] rd_raddr1_i,
   input  logic [RF_AW-1:0] rd_raddr2_i,
   input  logic [RF_AW-1:0] rd_waddr_i,
   output logic             rd_stall_o
);
   localparam int CW = $clog2(MAX_PEND + 1);

   logic [RF_NREG-1:0] pend_q, pend_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               set, clr;

   assign iss_ready_o = (cnt_q < CW'(MAX_PEND)) && !pend_q[iss_waddr_i];
   assign rd_stall_o  = pend_q[rd_raddr1_i] | pend_q[rd_raddr2_i] | pend_q[rd_waddr_i];

   // r0 issues are accepted but never tracked; a stray commit to an untracked
   // register must not underflow the count.
   assign set = iss_valid_i && iss_ready_o && (iss_waddr_i != '0);
   assign clr = commit_i && pend_q[commit_waddr_i];

   always_comb begin
      pend_d = pend_q;
      if (clr) pend_d[commit_waddr_i] = 1'b0;
      if (set) pend_d[iss_waddr_i] = 1'b1;
      pend_d[0] = 1'b0;
      cnt_d = cnt_q;
      case ({set, clr})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Regfile write-port arbiter: WB wins, one deferred long-latency result drains
// into idle WB slots. RF_ARB_STARVE_EN adds a starvation counter driving wb_hold.
module rf_wport_arbiter
   import rf_arb_pkg::*;
#(
   parameter int MAX_PEND   = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wb_wen,
   input  logic [RF_AW-1:0] wb_waddr,
   input  logic [RF_DW-1:0] wb_wdata,
   output logic             wb_hold,
   input  logic             iss_valid,
   input  logic [RF_AW-1:0] iss_waddr,
   output logic             iss_ready,
   input  logic             lu_valid,
   input  logic [RF_AW-1:0] lu_waddr,
   input  logic [RF_DW-1:0] lu_wdata,
   output logic             lu_ready,
   input  logic [RF_AW-1:0] rd_raddr1,
   input  logic [RF_AW-1:0] rd_raddr2,
   input  logic [RF_AW-1:0] rd_waddr,
   output logic             rd_stall,
   output logic             rf_wen,
   output logic [RF_AW-1:0] rf_waddr,
   output logic [RF_DW-1:0] rf_wdata
);
   if (MAX_PEND < 1 || MAX_PEND > 15) begin : g_bad_pend
      $error("MAX_PEND out of range");
   end
   if (STARVE_LIM < 1 || STARVE_LIM > 255) begin : g_bad_lim
      $error("STARVE_LIM out of range");
   end

   rf_wreq_t buf_q, buf_d, rf_req;
   logic     wb_busy, commit, accept;

   // Writes to r0 are dropped, so they never steal the slot from the buffer.
   assign wb_busy  = wb_wen && (wb_waddr != '0);
   assign commit   = buf_q.wen && !wb_busy;
   assign lu_ready = !buf_q.wen;
   assign accept   = lu_valid && lu_ready;

   always_comb begin
      buf_d = buf_q;
      if (commit)      buf_d.wen = 1'b0;
      else if (accept) buf_d = '{wen: 1'b1, waddr: lu_waddr, wdata: lu_wdata};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) buf_q <= '0;
      else       buf_q <= buf_d;
   end

   always_comb begin
      rf_req = '0;
      if (wb_busy)        rf_req = '{wen: 1'b1, waddr: wb_waddr, wdata: wb_wdata};
      else if (buf_q.wen) rf_req = buf_q;
   end

   assign rf_wen   = rf_req.wen;
   assign rf_waddr = rf_req.waddr;
   assign rf_wdata = rf_req.wdata;

`ifdef RF_ARB_STARVE_EN
   logic [7:0] starve_q, starve_d;
   logic       hold_q, hold_d, blocked;

   assign blocked = buf_q.wen && wb_busy;

   always_comb begin
      starve_d = starve_q;
      hold_d   = hold_q;
      if (commit) begin
         starve_d = '0;
         hold_d   = 1'b0;
      end else if (blocked) begin
         if (starve_q != 8'hFF) starve_d = starve_q + 8'd1;
         if (starve_q == 8'(STARVE_LIM - 1)) hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
         hold_q   <= 1'b0;
      end else begin
         starve_q <= starve_d;
         hold_q   <= hold_d;
      end
   end

   assign wb_hold = hold_q;
`else
   assign wb_hold = 1'b0;
`endif

   rf_scoreboard #(.MAX_PEND(MAX_PEND)) u_sb (
      .clk            (clk),
      .reset          (reset),
      .iss_valid_i    (iss_valid),
      .iss_waddr_i    (iss_waddr),
      .iss_ready_o    (iss_ready),
      .commit_i       (commit),
      .commit_waddr_i (buf_q.waddr),
      .rd_raddr1_i    (rd_raddr1),
      .rd_raddr2_i    (rd_raddr2),
      .rd_waddr_i     (rd_waddr),
      .rd_stall_o     (rd_stall)
   );
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the write-port rules.
module tb_rf_wport_arbiter;
   localparam int MAXP = 4;
   localparam int SLIM = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_wen = 1'b0;
   logic [4:0]  wb_waddr = '0;
   logic [31:0] wb_wdata = '0;
   logic        wb_hold;
   logic        iss_valid = 1'b0;
   logic [4:0]  iss_waddr = '0;
   logic        iss_ready;
   logic        lu_valid = 1'b0;
   logic [4:0]  lu_waddr = '0;
   logic [31:0] lu_wdata = '0;
   logic        lu_ready;
   logic [4:0]  rd_raddr1 = '0, rd_raddr2 = '0, rd_waddr = '0;
   logic        rd_stall;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;

   rf_wport_arbiter #(.MAX_PEND(MAXP), .STARVE_LIM(SLIM)) dut (
      .clk(clk), .reset(reset),
      .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_hold(wb_hold),
      .iss_valid(iss_valid), .iss_waddr(iss_waddr), .iss_ready(iss_ready),
      .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
      .rd_raddr1(rd_raddr1), .rd_raddr2(rd_raddr2), .rd_waddr(rd_waddr), .rd_stall(rd_stall),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_buf_v = 1'b0;
   logic [4:0]  m_buf_a = '0;
   logic [31:0] m_buf_d = '0;
   bit          m_pend [32];
   int          m_cnt = 0;
   int          m_starve = 0;
   bit          m_hold = 1'b0;
   bit          m_iss_acc = 1'b0, m_lu_acc = 1'b0;

   wire t_wbb     = wb_wen && (wb_waddr != 5'd0);
   wire t_iss_rdy = (m_cnt < MAXP) && !m_pend[iss_waddr];
   wire t_commit  = m_buf_v && !t_wbb;
   wire t_accept  = lu_valid && !m_buf_v;
   wire t_iss     = iss_valid && t_iss_rdy && (iss_waddr != 5'd0);
   wire m_stall   = m_pend[rd_raddr1] || m_pend[rd_raddr2] || m_pend[rd_waddr];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_buf_v <= 1'b0;
         for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
         m_cnt <= 0;
         m_starve <= 0;
         m_hold <= 1'b0;
         m_iss_acc <= 1'b0;
         m_lu_acc <= 1'b0;
      end else begin
         m_iss_acc <= iss_valid && t_iss_rdy;
         m_lu_acc  <= t_accept;
         if (t_commit) begin
            m_buf_v <= 1'b0;
            m_pend[m_buf_a] <= 1'b0;
         end
         if (t_accept) begin
            m_buf_v <= 1'b1;
            m_buf_a <= lu_waddr;
            m_buf_d <= lu_wdata;
         end
         if (t_iss) m_pend[iss_waddr] <= 1'b1;
         m_cnt <= m_cnt + (t_iss ? 1 : 0) - (t_commit ? 1 : 0);
`ifdef RF_ARB_STARVE_EN
         if (t_commit) begin
            m_starve <= 0;
            m_hold <= 1'b0;
         end else if (m_buf_v && t_wbb) begin
            if (m_starve < 255) m_starve <= m_starve + 1;
            if (m_starve == SLIM - 1) m_hold <= 1'b1;
         end
`endif
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rf_wen", rf_wen, t_wbb || m_buf_v);
         if (t_wbb) begin
            chk("rf_waddr_wb", rf_waddr, wb_waddr);
            chk("rf_wdata_wb", rf_wdata, wb_wdata);
         end else if (m_buf_v) begin
            chk("rf_waddr_buf", rf_waddr, m_buf_a);
            chk("rf_wdata_buf", rf_wdata, m_buf_d);
         end
         chk("lu_ready", lu_ready, !m_buf_v);
         chk("iss_ready", iss_ready, t_iss_rdy);
         chk("rd_stall", rd_stall, m_stall);
         chk("wb_hold", wb_hold, m_hold);
      end
   end

   // Long-latency results must target a pending register.
   always @(posedge clk) begin
      if (cmp_en && !reset && lu_valid) chk("lu_proto", m_pend[lu_waddr], 1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic deliver(input logic [4:0] a, input logic [31:0] d);
      lu_valid = 1'b1; lu_waddr = a; lu_wdata = d;
      step();
      lu_valid = 1'b0;
   endtask

   logic [4:0] outst[$];
   bit hold_last, force_idle;
   int idx;

   initial begin
      // Reset state
      wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hAA;
      #2;
      chk("rst_rf_wen", rf_wen, 1);
      chk("rst_rf_waddr", rf_waddr, 3);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; wb_wen = 1'b0; cmp_en = 1'b1;
      #1;
      chk("rst_lu_ready", lu_ready, 1);
      chk("rst_iss_ready", iss_ready, 1);
      chk("rst_rd_stall", rd_stall, 0);
      chk("rst_rf_wen0", rf_wen, 0);
      chk("rst_wb_hold", wb_hold, 0);

      // 1: idle WB, r5 result lands one cycle after accept
      iss_valid = 1'b1; iss_waddr = 5'd5;
      #1 chk("t1_iss_ready", iss_ready, 1);
      step();
      iss_valid = 1'b0; rd_raddr1 = 5'd5;
      #1 chk("t1_stall", rd_stall, 1);
      deliver(5'd5, 32'h1234);
      #1;
      chk("t1_rf_wen", rf_wen, 1);
      chk("t1_rf_waddr", rf_waddr, 5);
      chk("t1_rf_wdata", rf_wdata, 32'h1234);
      chk("t1_stall_commit", rd_stall, 1);
      chk("t1_lu_ready", lu_ready, 0);
      step();
      chk("t1_stall_clear", rd_stall, 0);
      chk("t1_rf_idle", rf_wen, 0);
      rd_raddr1 = 5'd0;

      // 2: WB busy three cycles with r5 buffered
      iss_valid = 1'b1; iss_waddr = 5'd5;
      step();
      iss_valid = 1'b0;
      deliver(5'd5, 32'h55);
      wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h77;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t2_rf_waddr_wb", rf_waddr, 7);
         chk("t2_lu_ready", lu_ready, 0);
         step();
      end
      wb_wen = 1'b0;
      #1;
      chk("t2_commit_waddr", rf_waddr, 5);
      chk("t2_commit_wdata", rf_wdata, 32'h55);
      step();
      chk("t2_rf_idle", rf_wen, 0);

      // 3: r0 issue never stalls and is not counted
      iss_valid = 1'b1; iss_waddr = 5'd0;
      #1 chk("t3_iss_r0", iss_ready, 1);
      step();
      iss_valid = 1'b0;
      #1 chk("t3_no_stall_r0", rd_stall, 0);

      // 4: fill to MAX_PEND, then WAW block
      for (int k = 1; k <= 4; k++) begin
         iss_valid = 1'b1; iss_waddr = 5'(k);
         #1 chk("t4_iss_fill", iss_ready, 1);
         step();
      end
      iss_valid = 1'b0; iss_waddr = 5'd8;
      #1 chk("t4_full", iss_ready, 0);
      iss_waddr = 5'd2;
      #1 chk("t4_full_waw", iss_ready, 0);
      deliver(5'd1, 32'h11);
      iss_waddr = 5'd9;
      #1;
      chk("t4_commit_r1", rf_waddr, 1);
      chk("t4_still_full", iss_ready, 0);
      step();
      iss_waddr = 5'd2;
      #1 chk("t4_waw_block", iss_ready, 0);
      iss_waddr = 5'd9;
      #1 chk("t4_room", iss_ready, 1);

      // 5: issue r6 in the same cycle r2 commits
      deliver(5'd2, 32'h22);
      iss_valid = 1'b1; iss_waddr = 5'd6;
      #1;
      chk("t5_iss_ready", iss_ready, 1);
      chk("t5_commit_r2", rf_waddr, 2);
      step();
      iss_valid = 1'b0; rd_raddr1 = 5'd6;
      #1 chk("t5_pend6", rd_stall, 1);
      rd_raddr1 = 5'd2;
      #1 chk("t5_pend2_clr", rd_stall, 0);
      iss_waddr = 5'd10;
      #1 chk("t5_cnt3", iss_ready, 1);
      iss_valid = 1'b1;
      step();
      iss_valid = 1'b0; iss_waddr = 5'd11;
      #1 chk("t5_cnt4", iss_ready, 0);
      rd_raddr1 = 5'd0;
      foreach (outst[i]) outst.delete(i);
      deliver(5'd3, 32'h33); step();
      deliver(5'd4, 32'h44); step();
      deliver(5'd6, 32'h66); step();
      deliver(5'd10, 32'hAA); step();

`ifdef RF_ARB_STARVE_EN
      // 6a: continuous WB starves the buffer until wb_hold
      iss_valid = 1'b1; iss_waddr = 5'd12;
      step();
      iss_valid = 1'b0;
      wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h7;
      deliver(5'd12, 32'hC);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("t6_hold", wb_hold, (k == 8) ? 1 : 0);
      end
      wb_wen = 1'b0;
      #1 chk("t6_commit", rf_waddr, 12);
      step();
      chk("t6_hold_clr", wb_hold, 0);
`endif

      // 6b: reset while a result is buffered
      iss_valid = 1'b1; iss_waddr = 5'd13;
      step();
      iss_valid = 1'b0;
      wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h7;
      deliver(5'd13, 32'hD);
      rd_raddr1 = 5'd13;
      #1 chk("t6_pre_stall", rd_stall, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_rf_waddr", rf_waddr, 7);
      chk("t6_rst_lu_ready", lu_ready, 1);
      chk("t6_rst_stall", rd_stall, 0);
      wb_wen = 1'b0;
      #1 chk("t6_rst_no_write", rf_wen, 0);
      step(); step();
      reset = 1'b0;
      step();
      chk("t6_post_rf_wen", rf_wen, 0);
      rd_raddr1 = 5'd0;

      // Randomized run
      hold_last = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (iss_valid && m_iss_acc && iss_waddr != 5'd0) outst.push_back(iss_waddr);
         if (lu_valid && m_lu_acc) lu_valid = 1'b0;
         force_idle = hold_last;
         hold_last = m_hold;
         wb_wen   = !force_idle && ($urandom_range(0, 9) < 6);
         wb_waddr = 5'($urandom_range(0, 31));
         wb_wdata = $urandom;
         iss_valid = ($urandom_range(0, 2) == 0);
         iss_waddr = 5'($urandom_range(0, 7));
         if (!lu_valid && outst.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, outst.size() - 1);
            lu_waddr = outst[idx];
            outst.delete(idx);
            lu_wdata = $urandom;
            lu_valid = 1'b1;
         end
         rd_raddr1 = 5'($urandom_range(0, 7));
         rd_raddr2 = 5'($urandom_range(0, 7));
         rd_waddr  = 5'($urandom_range(0, 7));
         step();
      end

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
